// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: memory-mapped register port of the external-interrupt controller.
//
// Signals:
//   bus_wr_i     register write strobe (driven by master)
//   bus_rd_i     register read strobe, no side effects (driven by master)
//   bus_addr_i   byte address, bits [1:0] ignored (driven by master)
//   bus_wdata_i  write data (driven by master)
//   bus_rdata_o  read data, combinational from address (driven by slave)
//
// Modports: master (firmware / bus side), slave (intr_ctrl).
interface intr_ctrl_if;
  logic        bus_wr_i;
  logic        bus_rd_i;
  logic [3:0]  bus_addr_i;
  logic [31:0] bus_wdata_i;
  logic [31:0] bus_rdata_o;

  modport master (
    output bus_wr_i,
    output bus_rd_i,
    output bus_addr_i,
    output bus_wdata_i,
    input  bus_rdata_o
  );

  modport slave (
    input  bus_wr_i,
    input  bus_rd_i,
    input  bus_addr_i,
    input  bus_wdata_i,
    output bus_rdata_o
  );
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: platform external-interrupt controller.
//
// Collects NUM_SRC peripheral interrupt lines, arbitrates eligible sources by
// fixed priority (lowest index wins), raises m_ext_intr_o with a matching
// mcause_o, hands the request over on the CSR claim pulse, and keeps the
// claimed source in service until firmware writes its id to COMPLETE.
//
// Parameters:
//   NUM_SRC     number of interrupt sources (1..16)
//   CAUSE_BASE  mcause_o = CAUSE_BASE + source id
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous active-high reset
//   src_i         peripheral interrupt lines, synchronous to clk_i
//   p_int_read_i  one-cycle claim pulse from the CSR unit
//   bus           register port (intr_ctrl_if.slave)
//   m_ext_intr_o  machine-external interrupt request (registered)
//   mcause_o      cause code for the request, 0 outside REQ (registered)
//
// Register map (bus_addr_i[3:2]):
//   0x0 ENABLE   RW  [NUM_SRC-1:0]
//   0x4 PENDING  R: pending vector, W1C in edge mode only
//   0x8 CLAIM    RO  [3:0] claimed id, [31] in service
//   0xC COMPLETE WO  [3:0] id
//
// Configuration macro: INTR_CTRL_EDGE_EN
//   defined   - rising-edge capture into sticky pending bits
//   undefined - level-sensitive, pending mirrors src_i
module intr_ctrl #(
  parameter int NUM_SRC    = 8,
  parameter int CAUSE_BASE = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               p_int_read_i,
  intr_ctrl_if.slave         bus,
  output logic               m_ext_intr_o,
  output logic [30:0]        mcause_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] req_onehot;
  logic [NUM_SRC-1:0] claim_onehot;
  logic [NUM_SRC-1:0] in_service_mask;
  logic [3:0]         req_id;
  logic [3:0]         claim_id;
  logic [3:0]         winner;
  logic               bus_wr_enable;
  logic               bus_wr_complete;
  logic               complete_hit;
  logic               withdraw;
  logic [31:0]        rdata;
  logic               unused_bus;

  assign bus_wr_enable   = bus.bus_wr_i && (bus.bus_addr_i[3:2] == 2'd0);
  assign bus_wr_complete = bus.bus_wr_i && (bus.bus_addr_i[3:2] == 2'd3);

  // One-hot forms avoid indexing a NUM_SRC-wide vector with a 4-bit id.
  assign req_onehot   = NUM_SRC'(1) << req_id;
  assign claim_onehot = NUM_SRC'(1) << claim_id;

  assign in_service_mask = (state == SERVICE) ? claim_onehot : '0;
  assign eligible        = pend & enable & ~in_service_mask;

  assign withdraw = !(|(enable & req_onehot)) || !(|(pend & req_onehot));

  assign complete_hit = (state == SERVICE) && bus_wr_complete &&
                        (bus.bus_wdata_i[3:0] == claim_id);

  // Fixed priority: scanning downwards leaves the lowest eligible index.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 4'(i);
    end
  end

`ifdef INTR_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] claim_clr;

  assign w1c_mask  = (bus.bus_wr_i && (bus.bus_addr_i[3:2] == 2'd1)) ?
                     bus.bus_wdata_i[NUM_SRC-1:0] : '0;
  assign claim_clr = ((state == REQ) && p_int_read_i) ? req_onehot : '0;

  // The new rising edge is OR-ed in last, so a capture beats a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q <= '0;
      pend  <= '0;
    end else begin
      src_q <= src_i;
      pend  <= (pend & ~w1c_mask & ~claim_clr) | (src_i & ~src_q);
    end
  end
`else
  assign pend = src_i;
`endif

  // ENABLE updates after this edge, so arbitration in the same cycle sees the old mask.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable <= '0;
    end else if (bus_wr_enable) begin
      enable <= bus.bus_wdata_i[NUM_SRC-1:0];
    end
  end

  // Request FSM. req_id and the outputs are locked on REQ entry and held,
  // so the cause sampled with the claim pulse always matches claim_id.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      req_id       <= '0;
      claim_id     <= '0;
      m_ext_intr_o <= 1'b0;
      mcause_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            state        <= REQ;
            req_id       <= winner;
            m_ext_intr_o <= 1'b1;
            mcause_o     <= 31'(CAUSE_BASE) + 31'(winner);
          end
        end
        REQ: begin
          if (p_int_read_i) begin
            state        <= SERVICE;
            claim_id     <= req_id;
            m_ext_intr_o <= 1'b0;
            mcause_o     <= '0;
          end else if (withdraw) begin
            state        <= IDLE;
            m_ext_intr_o <= 1'b0;
            mcause_o     <= '0;
          end
        end
        SERVICE: begin
          if (complete_hit) state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          m_ext_intr_o <= 1'b0;
          mcause_o     <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.bus_addr_i[3:2])
      2'd0:    rdata = 32'(enable);
      2'd1:    rdata = 32'(pend);
      2'd2:    rdata = {(state == SERVICE), 27'd0, claim_id};
      default: rdata = '0;
    endcase
  end

  assign bus.bus_rdata_o = rdata;

  // Reads have no side effects and only the low write-data bits are decoded.
  assign unused_bus = ^{bus.bus_rd_i, bus.bus_addr_i[1:0], bus.bus_wdata_i};

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: testbench for intr_ctrl.
//
// Directed scenarios (reset, priority, complete handshake, masking/withdraw,
// stray claims, edge capture when INTR_CTRL_EDGE_EN is defined) followed by a
// randomized run, all checked against a source-level reference model.
`timescale 1ns/1ps
module tb_intr_ctrl;
  localparam int NUM_SRC    = 8;
  localparam int CAUSE_BASE = 16;
`ifdef INTR_CTRL_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  localparam int LAT = EDGE ? 2 : 1;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [NUM_SRC-1:0] src_i;
  logic               p_int_read_i;
  logic               m_ext_intr_o;
  logic [30:0]        mcause_o;

  intr_ctrl_if bus ();

  intr_ctrl #(.NUM_SRC(NUM_SRC), .CAUSE_BASE(CAUSE_BASE)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .src_i        (src_i),
    .p_int_read_i (p_int_read_i),
    .bus          (bus),
    .m_ext_intr_o (m_ext_intr_o),
    .mcause_o     (mcause_o)
  );

  always #5 clk_i = ~clk_i;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: which source is requesting, which is in service,
  // the last claimed id, the enable mask and (edge mode) sticky pending bits.
  logic [NUM_SRC-1:0] m_en;
  logic [NUM_SRC-1:0] m_pend;
  logic [NUM_SRC-1:0] m_prev;
  int                 m_req;
  int                 m_svc;
  int                 m_claim;

  function automatic void model_reset();
    m_en    = '0;
    m_pend  = '0;
    m_prev  = '0;
    m_req   = -1;
    m_svc   = -1;
    m_claim = 0;
  endfunction

  function automatic void model_step();
    logic [NUM_SRC-1:0] pv;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] w1c;
    logic [1:0]         reg_sel;
    int                 nreq;
    int                 nsvc;
    reg_sel = bus.bus_addr_i[3:2];
    pv      = EDGE ? m_pend : src_i;
    clr     = '0;
    nreq    = m_req;
    nsvc    = m_svc;
    if (m_svc >= 0) begin
      if (bus.bus_wr_i && reg_sel == 2'd3 && bus.bus_wdata_i[3:0] == 4'(m_svc))
        nsvc = -1;
    end else if (m_req >= 0) begin
      if (p_int_read_i) begin
        nsvc      = m_req;
        m_claim   = m_req;
        clr[m_req] = 1'b1;
        nreq      = -1;
      end else if (!m_en[m_req] || !pv[m_req]) begin
        nreq = -1;
      end
    end else begin
      elig = pv & m_en;
      if (elig != '0) begin
        nreq = 0;
        while (elig[0] == 1'b0) begin
          elig = elig >> 1;
          nreq++;
        end
      end
    end
    m_req = nreq;
    m_svc = nsvc;
    w1c = (bus.bus_wr_i && reg_sel == 2'd1) ? bus.bus_wdata_i[NUM_SRC-1:0] : '0;
    if (EDGE) m_pend = (m_pend & ~w1c & ~clr) | (src_i & ~m_prev);
    m_prev = src_i;
    if (bus.bus_wr_i && reg_sel == 2'd0) m_en = bus.bus_wdata_i[NUM_SRC-1:0];
  endfunction

  function automatic logic exp_ext();
    return (m_req >= 0);
  endfunction

  function automatic logic [30:0] exp_cause();
    return (m_req >= 0) ? 31'(CAUSE_BASE + m_req) : 31'd0;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return 32'(m_en);
      2'd1:    return EDGE ? 32'(m_pend) : 32'(src_i);
      2'd2:    return {(m_svc >= 0), 27'd0, 4'(m_claim)};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: the model consumes the inputs driven for this edge, then the
  // one-shot strobes are dropped 1 ns after the edge.
  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
    p_int_read_i    = 1'b0;
    bus.bus_wr_i    = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.bus_wr_i    = 1'b1;
    bus.bus_addr_i  = a;
    bus.bus_wdata_i = d;
    tick();
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.bus_addr_i = a;
    bus.bus_rd_i   = 1'b1;
    #1;
    d = bus.bus_rdata_o;
    bus.bus_rd_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_i           = 1'b1;
    src_i           = '0;
    p_int_read_i    = 1'b0;
    bus.bus_wr_i    = 1'b0;
    bus.bus_rd_i    = 1'b0;
    bus.bus_addr_i  = '0;
    bus.bus_wdata_i = '0;
    model_reset();
    #1;
    compared++;
    if (m_ext_intr_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ext: got %0b want 0", m_ext_intr_o);
    end
    compared++;
    if (mcause_o !== 31'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_cause: got %0d want 0", mcause_o);
    end
    rd(4'h0, d);
    compared++;
    if (d !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_enable: got 0x%08h want 0x00000000", d);
    end
    rd(4'h8, d);
    compared++;
    if (d !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_claim: got 0x%08h want 0x00000000", d);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_priority();
    logic [31:0] d;
    bus_write(4'h0, 32'hFF);
    src_i = 8'h24;
    repeat (LAT) tick();
    compared++;
    if (m_ext_intr_o !== 1'b1 || mcause_o !== 31'd18) begin
      mismatched++;
      $display("[TB] FAIL prio_req: got ext=%0b cause=%0d want ext=1 cause=18", m_ext_intr_o, mcause_o);
    end
    tick();
    compared++;
    if (mcause_o !== 31'd18) begin
      mismatched++;
      $display("[TB] FAIL prio_hold: got cause=%0d want 18", mcause_o);
    end
    p_int_read_i = 1'b1;
    #1;
    compared++;
    if (mcause_o !== 31'd18 || m_ext_intr_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL prio_at_claim: got ext=%0b cause=%0d want ext=1 cause=18", m_ext_intr_o, mcause_o);
    end
    tick();
    compared++;
    if (m_ext_intr_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL prio_claimed_ext: got %0b want 0", m_ext_intr_o);
    end
    rd(4'h8, d);
    compared++;
    if (d !== 32'h8000_0002) begin
      mismatched++;
      $display("[TB] FAIL prio_claim_reg: got 0x%08h want 0x80000002", d);
    end
  endtask

  task automatic test_complete();
    logic [31:0] d;
    src_i = 8'h20;
    bus_write(4'hC, 32'd5);
    rd(4'h8, d);
    compared++;
    if (d !== 32'h8000_0002 || m_ext_intr_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL complete_wrong_id: got claim=0x%08h ext=%0b want 0x80000002 ext=0", d, m_ext_intr_o);
    end
    bus_write(4'hC, 32'd2);
    rd(4'h8, d);
    compared++;
    if (d !== 32'h0000_0002) begin
      mismatched++;
      $display("[TB] FAIL complete_idle_claim: got 0x%08h want 0x00000002", d);
    end
    tick();
    compared++;
    if (m_ext_intr_o !== 1'b1 || mcause_o !== 31'd21) begin
      mismatched++;
      $display("[TB] FAIL complete_rereq: got ext=%0b cause=%0d want ext=1 cause=21", m_ext_intr_o, mcause_o);
    end
    p_int_read_i = 1'b1;
    tick();
    bus_write(4'hC, 32'd5);
    src_i = '0;
    tick();
    compared++;
    if (m_ext_intr_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL complete_quiet: got ext=%0b want 0", m_ext_intr_o);
    end
  endtask

  task automatic test_mask_withdraw();
    bus_write(4'h0, 32'h0);
    src_i = 8'h08;
    repeat (LAT + 1) tick();
    compared++;
    if (m_ext_intr_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mask_noreq: got ext=%0b want 0", m_ext_intr_o);
    end
    bus_write(4'h0, 32'h08);
    compared++;
    if (m_ext_intr_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mask_old_enable: got ext=%0b want 0", m_ext_intr_o);
    end
    tick();
    compared++;
    if (m_ext_intr_o !== 1'b1 || mcause_o !== 31'd19) begin
      mismatched++;
      $display("[TB] FAIL mask_req: got ext=%0b cause=%0d want ext=1 cause=19", m_ext_intr_o, mcause_o);
    end
    bus_write(4'h0, 32'h0);
    compared++;
    if (m_ext_intr_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL withdraw_hold: got ext=%0b want 1", m_ext_intr_o);
    end
    tick();
    compared++;
    if (m_ext_intr_o !== 1'b0 || mcause_o !== 31'd0) begin
      mismatched++;
      $display("[TB] FAIL withdraw_drop: got ext=%0b cause=%0d want ext=0 cause=0", m_ext_intr_o, mcause_o);
    end
    src_i = '0;
  endtask

  task automatic test_stray_claim();
    logic [31:0] d;
    bus_write(4'h4, 32'hFF);
    p_int_read_i = 1'b1;
    tick();
    rd(4'h8, d);
    compared++;
    if (d !== model_read(4'h8) || m_ext_intr_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stray_idle: got claim=0x%08h ext=%0b want 0x%08h ext=0", d, m_ext_intr_o, model_read(4'h8));
    end
    bus_write(4'h0, 32'h02);
    src_i = 8'h02;
    repeat (LAT) tick();
    compared++;
    if (m_ext_intr_o !== 1'b1 || mcause_o !== 31'd17) begin
      mismatched++;
      $display("[TB] FAIL stray_req: got ext=%0b cause=%0d want ext=1 cause=17", m_ext_intr_o, mcause_o);
    end
    p_int_read_i = 1'b1;
    tick();
    p_int_read_i = 1'b1;
    tick();
    rd(4'h8, d);
    compared++;
    if (d !== 32'h8000_0001 || m_ext_intr_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stray_service: got claim=0x%08h ext=%0b want 0x80000001 ext=0", d, m_ext_intr_o);
    end
    src_i = '0;
    bus_write(4'hC, 32'd1);
    tick();
  endtask

`ifdef INTR_CTRL_EDGE_EN
  task automatic test_edge();
    logic [31:0] d;
    bus_write(4'h4, 32'hFF);
    bus_write(4'h0, 32'h80);
    src_i = 8'h80;
    tick();
    src_i = '0;
    rd(4'h4, d);
    compared++;
    if (d !== 32'h80 || m_ext_intr_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL edge_capture: got pend=0x%08h ext=%0b want 0x80 ext=0", d, m_ext_intr_o);
    end
    tick();
    compared++;
    if (m_ext_intr_o !== 1'b1 || mcause_o !== 31'd23) begin
      mismatched++;
      $display("[TB] FAIL edge_req: got ext=%0b cause=%0d want ext=1 cause=23", m_ext_intr_o, mcause_o);
    end
    p_int_read_i = 1'b1;
    tick();
    rd(4'h4, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL edge_claim_clear: got pend=0x%08h want 0x0", d);
    end
    bus_write(4'hC, 32'd7);
    bus_write(4'h0, 32'h0);
    src_i = 8'h80;
    tick();
    src_i = '0;
    bus_write(4'h4, 32'h80);
    bus_write(4'h0, 32'h80);
    tick();
    rd(4'h4, d);
    compared++;
    if (d !== 32'h0 || m_ext_intr_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL edge_w1c: got pend=0x%08h ext=%0b want 0x0 ext=0", d, m_ext_intr_o);
    end
    src_i = 8'h40;
    bus_write(4'h4, 32'h40);
    src_i = '0;
    rd(4'h4, d);
    compared++;
    if (d !== 32'h40) begin
      mismatched++;
      $display("[TB] FAIL edge_capture_wins: got pend=0x%08h want 0x40", d);
    end
    bus_write(4'h4, 32'hFF);
  endtask
`endif

  task automatic test_reset_mid_req();
    logic [31:0] d;
    bus_write(4'h0, 32'h01);
    src_i = 8'h01;
    repeat (LAT) tick();
    compared++;
    if (m_ext_intr_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midreset_pre: got ext=%0b want 1", m_ext_intr_o);
    end
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    compared++;
    if (m_ext_intr_o !== 1'b0 || mcause_o !== 31'd0) begin
      mismatched++;
      $display("[TB] FAIL midreset_out: got ext=%0b cause=%0d want ext=0 cause=0", m_ext_intr_o, mcause_o);
    end
    rd(4'h8, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL midreset_claim: got 0x%08h want 0x0", d);
    end
    rd(4'h0, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL midreset_enable: got 0x%08h want 0x0", d);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    src_i = '0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] wd;
    logic [3:0]  a;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) src_i = NUM_SRC'($urandom);
      p_int_read_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        a  = 4'($urandom);
        wd = $urandom;
        if (a[3:2] == 2'd3 && m_svc >= 0 && $urandom_range(0, 1) == 1)
          wd[3:0] = 4'(m_svc);
        bus.bus_wr_i    = 1'b1;
        bus.bus_addr_i  = a;
        bus.bus_wdata_i = wd;
      end
      tick();
      compared++;
      if (m_ext_intr_o !== exp_ext() || mcause_o !== exp_cause()) begin
        mismatched++;
        $display("[TB] FAIL rand_out[%0d]: got ext=%0b cause=%0d want ext=%0b cause=%0d",
                 n, m_ext_intr_o, mcause_o, exp_ext(), exp_cause());
      end
      a = 4'($urandom);
      rd(a, d);
      compared++;
      if (d !== model_read(a)) begin
        mismatched++;
        $display("[TB] FAIL rand_read[%0d] addr=0x%h: got 0x%08h want 0x%08h", n, a, d, model_read(a));
      end
    end
  endtask

  initial begin
    $display("[TB] starting, edge mode = %0b", EDGE);
    test_reset();
    test_priority();
    test_complete();
    test_mask_withdraw();
    test_stray_claim();
`ifdef INTR_CTRL_EDGE_EN
    test_edge();
`endif
    test_reset_mid_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
